mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle sequencing controller for the MIPS datapath. Replaces the single-cycle combinational control path: it steps each instruction through fetch, decode, execute, memory and write-back states, and drives the register file, ALU, memory and PC enables one state at a time. A single shared memory port with a request/acknowledge handshake serves both instruction and data accesses. The block also produces a halt indication and a retired-instruction count for the bench.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- opcode  in  6  instruction[31:26] from the instruction register (valid from DECODE onward)
- zero_flag  in  1  ALU zero output
- mem_ack  in  1  memory access complete this cycle
- mem_req  out  1  memory access request, held until ack
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- ir_write  out  1  load instruction register and memory data register
- pc_en  out  1  PC load enable (see Operation)
- pc_src  out  1  PC source: 0 = ALU result (PC+4), 1 = branch target register
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU result, 1 = memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (immediate ops)
- halted  out  1  sticky; set on halt opcode
- illegal  out  1  sticky; set on unsupported opcode
- state  out  4  current state (debug)
- retired  out  CNT_W  retired-instruction count

## Operation
- Encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, HALT=11. Codes 12–15 go to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, halt 111111.
- FETCH: mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - Stay in FETCH while mem_ack=0.
  - On mem_ack=1: ir_write=1, pc_en=1, pc_src=0; go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target is computed and registered by the datapath).
  - lw/sw → MEM_ADDR; R-type → R_EXEC; addi/andi/ori → I_EXEC; beq/bne → BRANCH; halt → HALT and set halted.
  - Any other opcode: set illegal, go to FETCH. The instruction is not retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: mem_req=1, mem_read=1, iord=1. On ack: ir_write=0, MDR is loaded by the datapath; go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, iord=1. On ack go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11; go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, then FETCH.
  - pc_en = (beq & zero_flag) | (bne & ~zero_flag). This is the only Mealy output; it is combinational on zero_flag.
- HALT: absorbing state; all strobes 0. Only rst exits it.
- retired increments by 1 on the last cycle of each completed instruction:
  - MEM_WB, R_WB, I_WB, BRANCH;
  - MEM_WRITE with mem_ack=1.
  - Wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.

## Timing
- Reset values: state=FETCH, retired=0, halted=0, illegal=0. While rst=1, every control output is forced to 0, including mem_req.
- First mem_req is asserted in the cycle after rst deasserts.
- Latency with zero-wait memory (ack in the first request cycle):
  - R-type, I-type: 4 cycles
  - beq/bne: 3 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle adds 1 cycle.
- Handshake:
  - mem_req and the address/strobe outputs stay stable until the cycle mem_ack=1 is sampled.
  - mem_ack outside a request state is ignored.
- rst mid-access (any state, including HALT or a pending mem_req) → FETCH on the next edge; the interrupted instruction is not counted.
- rst and mem_ack in the same cycle: rst wins.

## Test plan
- Reset: hold rst=1 for 2 cycles with mem_ack=1 → all outputs 0, state=0, retired=0. The next cycle shows mem_req=1, iord=0.
- add R-type, zero-wait memory → states 0,1,6,7. reg_write=1 with reg_dst=1 in cycle 4. retired=1.
- lw, with memory ack delayed 3 cycles in both FETCH and MEM_READ → states 0×4, 1, 2, 3×4, 4 (11 cycles). mem_req is held throughout each wait. retired=1.
- beq with zero_flag=1, then bne with zero_flag=1 → pc_en=1 with pc_src=1 in the first BRANCH cycle and pc_en=0 in the second. retired increments by 2.
- Opcode 111111 → HALT, halted=1, no mem_req for 20 cycles. Opcode 010000 → illegal=1, back to FETCH, retired unchanged.
- rst asserted during a MEM_WRITE wait → mem_write drops immediately, state=FETCH after the edge, retired unchanged.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory port between the multi-cycle controller and the memory.
// The controller is the master: it requests, the memory acknowledges.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_ack;
    logic iord;
    logic mem_read;
    logic mem_write;

    modport master (
        output mem_req,
        output iord,
        output mem_read,
        output mem_write,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  mem_read,
        input  mem_write,
        output mem_ack
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: walks each instruction through
// fetch/decode/execute/memory/write-back and drives the datapath enables.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0]                   opcode,
    input  logic                         zero_flag,
    mips_multicycle_ctrl_if.master       mem,
    output logic                         ir_write,
    output logic                         pc_en,
    output logic                         pc_src,
    output logic                         reg_dst,
    output logic                         mem_to_reg,
    output logic                         reg_write,
    output logic                         alu_src_a,
    output logic [1:0]                   alu_src_b,
    output logic [1:0]                   alu_op,
    output logic                         halted,
    output logic                         illegal,
    output logic [3:0]                   state,
    output logic [CNT_W-1:0]             retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_HALT      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               r_halted;
    logic               r_illegal;

    logic               w_mem_req;
    logic               w_iord;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_ir_write;
    logic               w_pc_en;
    logic               w_pc_src;
    logic               w_reg_dst;
    logic               w_mem_to_reg;
    logic               w_reg_write;
    logic               w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [1:0]         w_alu_op;
    logic               w_retire;
    logic               w_set_halt;
    logic               w_set_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_set_halt)
                r_halted <= 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_mem_req     = 1'b0;
        w_iord        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_src      = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 2'b00;
        w_retire      = 1'b0;
        w_set_halt    = 1'b0;
        w_set_illegal = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem.mem_ack) begin
                    w_ir_write = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:             w_next = S_MEM_ADDR;
                    OP_RTYPE:                 w_next = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
                    OP_BEQ, OP_BNE:           w_next = S_BRANCH;
                    OP_HALT: begin
                        w_next     = S_HALT;
                        w_set_halt = 1'b1;
                    end
                    default: begin
                        w_next        = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                if (opcode == OP_SW)
                    w_next = S_MEM_WRITE;
                else if (opcode == OP_LW)
                    w_next = S_MEM_READ;
                else
                    w_next = S_FETCH;
            end
            S_MEM_READ: begin
                w_mem_req  = 1'b1;
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (mem.mem_ack)
                    w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (mem.mem_ack) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b11;
                w_next      = S_I_WB;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 1'b1;
                // Only Mealy output: taken decision follows zero_flag combinationally.
                w_pc_en     = ((opcode == OP_BEQ) & zero_flag) |
                              ((opcode == OP_BNE) & ~zero_flag);
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces every control strobe low in the same cycle, not just after the edge.
    assign mem.mem_req   = w_mem_req    & ~rst;
    assign mem.iord      = w_iord       & ~rst;
    assign mem.mem_read  = w_mem_read   & ~rst;
    assign mem.mem_write = w_mem_write  & ~rst;
    assign ir_write      = w_ir_write   & ~rst;
    assign pc_en         = w_pc_en      & ~rst;
    assign pc_src        = w_pc_src     & ~rst;
    assign reg_dst       = w_reg_dst    & ~rst;
    assign mem_to_reg    = w_mem_to_reg & ~rst;
    assign reg_write     = w_reg_write  & ~rst;
    assign alu_src_a     = w_alu_src_a  & ~rst;
    assign alu_src_b     = rst ? 2'b00 : w_alu_src_b;
    assign alu_op        = rst ? 2'b00 : w_alu_op;

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a fixed vector table, then an
// instruction-level model that expands each instruction into expected cycles.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero_flag;
    logic        ir_write, pc_en, pc_src, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        halted, illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if mif();

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .mem        (mif),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    // Control word: {req,iord,rd,wr,ir_write,pc_en,pc_src,reg_dst,mem_to_reg,reg_write,src_a,src_b[1:0],alu_op[1:0]}
    localparam logic [14:0] B_REQ = 15'h4000, B_IORD = 15'h2000, B_RD = 15'h1000, B_WR = 15'h0800;
    localparam logic [14:0] B_IRW = 15'h0400, B_PCEN = 15'h0200, B_PCSRC = 15'h0100, B_RDST = 15'h0080;
    localparam logic [14:0] B_M2R = 15'h0040, B_RW = 15'h0020, B_SRCA = 15'h0010;
    localparam logic [14:0] W_FETCH = B_REQ | B_RD | 15'h0004;
    localparam logic [14:0] W_FA    = W_FETCH | B_IRW | B_PCEN;
    localparam logic [14:0] W_DEC   = 15'h000C;
    localparam logic [14:0] W_MADDR = B_SRCA | 15'h0008;
    localparam logic [14:0] W_MRD   = B_REQ | B_IORD | B_RD;
    localparam logic [14:0] W_MWB   = B_RW | B_M2R;
    localparam logic [14:0] W_MWR   = B_REQ | B_IORD | B_WR;
    localparam logic [14:0] W_REX   = B_SRCA | 15'h0002;
    localparam logic [14:0] W_RWB   = B_RW | B_RDST;
    localparam logic [14:0] W_IEX   = B_SRCA | 15'h0008 | 15'h0003;
    localparam logic [14:0] W_IWB   = B_RW;
    localparam logic [14:0] W_BR    = B_SRCA | B_PCSRC | 15'h0001;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_HALT = 6'h3F;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        ack;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [31:0] ret;
        logic        hlt;
        logic        ill;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned n_cyc    = 0;
    vec_t        tbl[16];
    vec_t        q[$];
    logic [31:0] m_ret;
    logic        m_hlt, m_ill;

    function automatic logic [14:0] dut_ctl();
        return {mif.mem_req, mif.iord, mif.mem_read, mif.mem_write, ir_write, pc_en, pc_src,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", n_cyc, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst          = v.rst;
        opcode       = v.op;
        zero_flag    = v.zero;
        mif.mem_ack  = v.ack;
        @(negedge clk);
        chk("state",   {28'd0, state}, {28'd0, v.st});
        chk("ctl",     {17'd0, dut_ctl()}, {17'd0, v.ctl});
        chk("retired", retired, v.ret);
        chk("halted",  {31'd0, halted}, {31'd0, v.hlt});
        chk("illegal", {31'd0, illegal}, {31'd0, v.ill});
        n_cyc++;
    endtask

    task automatic push(input logic r, input logic [5:0] op, input logic z, input logic a,
                        input logic [3:0] st, input logic [14:0] c);
        vec_t v;
        v = '{r, op, z, a, st, c, m_ret, m_hlt, m_ill};
        q.push_back(v);
    endtask

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    // Expands one instruction into its expected per-cycle behaviour.
    task automatic model_instr(input logic [5:0] op, input int unsigned wf, input int unsigned wm,
                               input logic z);
        logic taken;
        for (int unsigned i = 0; i < wf; i++) push(1'b0, op, rb(), 1'b0, 4'd0, W_FETCH);
        push(1'b0, op, rb(), 1'b1, 4'd0, W_FA);
        push(1'b0, op, rb(), rb(), 4'd1, W_DEC);
        case (op)
            OP_R: begin
                push(1'b0, op, rb(), rb(), 4'd6, W_REX);
                push(1'b0, op, rb(), rb(), 4'd7, W_RWB);
                m_ret++;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                push(1'b0, op, rb(), rb(), 4'd8, W_IEX);
                push(1'b0, op, rb(), rb(), 4'd9, W_IWB);
                m_ret++;
            end
            OP_LW: begin
                push(1'b0, op, rb(), rb(), 4'd2, W_MADDR);
                for (int unsigned i = 0; i < wm; i++) push(1'b0, op, rb(), 1'b0, 4'd3, W_MRD);
                push(1'b0, op, rb(), 1'b1, 4'd3, W_MRD);
                push(1'b0, op, rb(), rb(), 4'd4, W_MWB);
                m_ret++;
            end
            OP_SW: begin
                push(1'b0, op, rb(), rb(), 4'd2, W_MADDR);
                for (int unsigned i = 0; i < wm; i++) push(1'b0, op, rb(), 1'b0, 4'd5, W_MWR);
                push(1'b0, op, rb(), 1'b1, 4'd5, W_MWR);
                m_ret++;
            end
            OP_BEQ, OP_BNE: begin
                taken = (op == OP_BEQ) ? z : ~z;
                push(1'b0, op, z, rb(), 4'd10, W_BR | (taken ? B_PCEN : 15'h0));
                m_ret++;
            end
            OP_HALT: m_hlt = 1'b1;
            default: m_ill = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_ret = '0;
        m_hlt = 1'b0;
        m_ill = 1'b0;
    endtask

    task automatic run_q();
        while (q.size() > 0) apply(q.pop_front());
    endtask

    function automatic logic is_known(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_HALT};
    endfunction

    logic [5:0] ops [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI};

    initial begin
        rst         = 1'b1;
        opcode      = 6'h00;
        zero_flag   = 1'b0;
        mif.mem_ack = 1'b1;

        // reset (ack held high), add, beq taken, bne not taken, illegal 010000
        tbl[0]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd0,  15'h0,          32'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, OP_R,   1'b0, 1'b1, 4'd0,  15'h0,          32'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, OP_R,   1'b0, 1'b0, 4'd0,  W_FETCH,        32'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, OP_R,   1'b0, 1'b1, 4'd0,  W_FA,           32'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, OP_R,   1'b0, 1'b1, 4'd1,  W_DEC,          32'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, OP_R,   1'b0, 1'b1, 4'd6,  W_REX,          32'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, OP_R,   1'b0, 1'b1, 4'd7,  W_RWB,          32'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, OP_BEQ, 1'b1, 1'b1, 4'd0,  W_FA,           32'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, OP_BEQ, 1'b1, 1'b0, 4'd1,  W_DEC,          32'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, OP_BEQ, 1'b1, 1'b0, 4'd10, W_BR | B_PCEN,  32'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, OP_BNE, 1'b1, 1'b1, 4'd0,  W_FA,           32'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, OP_BNE, 1'b1, 1'b1, 4'd1,  W_DEC,          32'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, OP_BNE, 1'b1, 1'b1, 4'd10, W_BR,           32'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 6'h10,  1'b0, 1'b1, 4'd0,  W_FA,           32'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 6'h10,  1'b0, 1'b0, 4'd1,  W_DEC,          32'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b0, OP_R,   1'b0, 1'b0, 4'd0,  W_FETCH,        32'd3, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) apply(tbl[i]);

        m_ret = 32'd3;
        m_hlt = 1'b0;
        m_ill = 1'b1;

        // lw with three wait cycles on both accesses: 11 cycles
        model_instr(OP_LW, 3, 3, 1'b0);
        run_q();

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_known(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
        run_q();

        // reset during a MEM_WRITE wait, with ack coinciding with rst
        model_instr(OP_R, 0, 0, 1'b0);
        push(1'b0, OP_SW, 1'b0, 1'b1, 4'd0, W_FA);
        push(1'b0, OP_SW, 1'b0, 1'b0, 4'd1, W_DEC);
        push(1'b0, OP_SW, 1'b0, 1'b0, 4'd2, W_MADDR);
        push(1'b0, OP_SW, 1'b0, 1'b0, 4'd5, W_MWR);
        push(1'b1, OP_SW, 1'b0, 1'b1, 4'd5, 15'h0);
        model_reset();
        push(1'b0, OP_SW, 1'b0, 1'b0, 4'd0, W_FETCH);
        model_instr(OP_SW, 1, 0, 1'b0);
        run_q();

        // halt absorbs for 20 cycles even with ack toggling; only rst leaves it
        model_instr(OP_HALT, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) push(1'b0, OP_HALT, rb(), rb(), 4'd11, 15'h0);
        push(1'b1, OP_HALT, 1'b0, 1'b1, 4'd11, 15'h0);
        model_reset();
        model_instr(OP_ADDI, 1, 0, 1'b0);
        model_instr(OP_BNE, 0, 0, 1'b0);
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
